// File: rtl/seg_fade_chaser.sv
// seg_fade_chaser: sequence-table LED/segment chaser with per-channel PWM fading trails.
// Ports: clk, reset (sync, active-high); speed[2:0] step rate (7 fastest);
//        dir (wrap direction, 1 = ascending); bounce (ping-pong traversal);
//        pause (freeze stepping, fading continues); seg_out[NUM_CH] PWM drive
//        (active-low when COMMON_ANODE); pos current sequence index;
//        step_pulse one-cycle pulse per position change.
// Build option: define SEG_FADE_LINEAR_EN for linear (bright-1) decay instead of bright>>1.
module seg_fade_chaser #(
    parameter int NUM_CH = 8,
    parameter int BRIGHT_W = 5,
    parameter int SPEED_W = 24,
    parameter int FADE_W = 21,
    parameter int SEQ_LEN = 8,
    parameter logic [4*SEQ_LEN-1:0] SEQ = 32'h5623_4610,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 speed,
    input  logic                       dir,
    input  logic                       bounce,
    input  logic                       pause,
    output logic [NUM_CH-1:0]          seg_out,
    output logic [$clog2(SEQ_LEN)-1:0] pos,
    output logic                       step_pulse
);
    localparam int PW = $clog2(SEQ_LEN);
    localparam logic [PW-1:0] LAST = PW'(SEQ_LEN - 1);
    typedef enum logic {UP, DOWN} heading_t;
    heading_t head, head_nxt;
    logic [2:0] speed_r;
    logic dir_r, bounce_r, pause_r;
    logic [SPEED_W-1:0] tmr, tmr_nxt, period;
    logic [PW-1:0] pos_nxt;
    logic step, tick;
    logic [FADE_W-1:0] fade_cnt;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [NUM_CH-1:0] on;
    logic [3:0] cur_ch;
    // Slower speed codes invert into larger high bits of the period.
    assign period = {~speed_r, {(SPEED_W-3){1'b1}}};
    assign cur_ch = SEQ[{pos, 2'b00} +: 4];
    assign tick = &fade_cnt;
    always_comb begin
        step = !pause_r && (tmr >= period);
        tmr_nxt = pause_r ? tmr : (step ? '0 : tmr + 1'b1);
        pos_nxt = pos;
        head_nxt = head;
        if (step) begin
            if (bounce_r) begin
                // Endpoints turn around without repeating the end position.
                if (head == UP) begin
                    head_nxt = (pos == LAST) ? DOWN : UP;
                    pos_nxt = (pos == LAST) ? LAST - 1'b1 : pos + 1'b1;
                end else begin
                    head_nxt = (pos == '0) ? UP : DOWN;
                    pos_nxt = (pos == '0) ? PW'(1) : pos - 1'b1;
                end
            end else begin
                pos_nxt = dir_r ? ((pos == LAST) ? '0 : pos + 1'b1)
                                : ((pos == '0) ? LAST : pos - 1'b1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_r <= '0;
            dir_r <= 1'b0;
            bounce_r <= 1'b0;
            pause_r <= 1'b0;
            tmr <= '0;
            pos <= '0;
            head <= UP;
            step_pulse <= 1'b0;
            fade_cnt <= '0;
            pwm_cnt <= '0;
            seg_out <= {NUM_CH{COMMON_ANODE}};
        end else begin
            speed_r <= speed;
            dir_r <= dir;
            bounce_r <= bounce;
            pause_r <= pause;
            tmr <= tmr_nxt;
            pos <= pos_nxt;
            head <= head_nxt;
            step_pulse <= step;
            fade_cnt <= fade_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            seg_out <= COMMON_ANODE ? ~on : on;
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [BRIGHT_W-1:0] bright, decayed;
`ifdef SEG_FADE_LINEAR_EN
        assign decayed = bright - 1'b1;
`else
        assign decayed = bright >> 1;
`endif
        // Nonzero guard keeps zero fully dark when pwm_cnt wraps to 0.
        assign on[i] = (bright != '0) && (bright >= pwm_cnt);
        always_ff @(posedge clk) begin
            if (reset)
                bright <= '0;
            else if (cur_ch == 4'(i))
                bright <= '1;
            else if (tick && bright != '0)
                bright <= decayed;
        end
    end
endmodule

// File: doc/seg_fade_chaser.md
# seg_fade_chaser

Parametrised LED/segment chaser with per-channel PWM fading trails, for TinyTapeout-class designs driving a 7-segment display or LED bar. A programmable sequence table selects which channel lights at each step. Wrap or ping-pong traversal, adjustable step rate, pause and common-anode/cathode output are supported. Sits directly behind the io_in/io_out wrapper; the wrapper maps pins to ports.

## Interface
- NUM_CH, 8: number of output channels (2..16)
- BRIGHT_W, 5: brightness/PWM resolution bits
- SPEED_W, 24: step-timer width (≥4)
- FADE_W, 21: fade-tick prescaler width
- SEQ_LEN, 8: sequence table entries (2..16)
- SEQ, 8×4-bit packed {5,6,2,3,4,6,1,0}: entry k at bits [4k+3:4k]; channel index per step; values ≥NUM_CH light nothing
- COMMON_ANODE, 1: 1 = outputs active-low
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- speed  in  3  step rate; 7 fastest, 0 slowest
- dir  in  1  wrap mode: 1 = ascending, 0 = descending
- bounce  in  1  1 = ping-pong traversal, dir ignored
- pause  in  1  freeze step timer and position; fading continues
- seg_out  out  NUM_CH  PWM channel drive, polarity per COMMON_ANODE
- pos  out  clog2(SEQ_LEN)  current sequence index
- step_pulse  out  1  one-cycle pulse on each position change

## Operation
- speed, dir, bounce, pause registered once (1-cycle input latency).
- period = {~speed_r, {SPEED_W-3{1'b1}}}.
- Step timer: when not paused, if tmr ≥ period then tmr←0, step, else tmr+1. Lowering period below tmr forces a step next cycle.
- Wrap mode: dir=1 → pos+1, SEQ_LEN-1→0; dir=0 → pos-1, 0→SEQ_LEN-1.
- Bounce mode: internal heading (reset = up). At pos=SEQ_LEN-1 heading up: heading←down, pos←SEQ_LEN-2. Mirror at 0. Otherwise move one step by heading. Heading is kept across mode changes.
- Brightness: one BRIGHT_W register per channel. Every cycle, channel SEQ[pos] loads all-ones. Load has priority over fade on the same cycle.
- Fade: free-running fade_cnt. Tick when fade_cnt = 2^FADE_W-1. On tick, every non-loaded channel with bright≠0 decays by bright>>1.
- PWM: free-running pwm_cnt (BRIGHT_W bits, +1 per cycle). on[i] = (bright[i]≠0) && (bright[i] ≥ pwm_cnt). seg_out = on, or ~on if COMMON_ANODE. Registered.
- Full brightness gives a continuous on. Zero gives a continuous off.

## Timing
- Reset values: tmr, fade_cnt, pwm_cnt, pos, all brightness = 0; heading up; step_pulse 0; seg_out all inactive (all-ones if COMMON_ANODE). No channel is loaded during reset.
- First cycle after reset: SEQ[0] is loaded. Its seg_out turns active 2 cycles after reset release (load, then register).
- Unpaused step interval = period+1 cycles. pos and step_pulse update on the same edge.
- pause asserted: tmr and pos hold from the cycle after pause_r. step_pulse stays 0. On release, counting resumes from the held tmr.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of pause or bounce.

## Configuration
- SEG_FADE_LINEAR_EN defined: decay is bright-1 (linear, 2^BRIGHT_W-1 ticks to dark).
- Undefined: decay is bright>>1 (exponential, BRIGHT_W ticks to dark).
- All other behaviour is identical.

## Test plan
Parameters for all scenarios: SPEED_W=6, FADE_W=3, BRIGHT_W=3, NUM_CH=8, default SEQ, COMMON_ANODE=1.
- Reset, speed=7, dir=1, bounce=0 -> seg_out=8'hFF during reset. Steps every 8 cycles, pos 0,1,…,7,0. step_pulse 1 cycle wide. seg_out[SEQ[pos]] continuously 0.
- dir=0 from pos=0 -> next pos=7. speed=6 -> step interval 16 cycles.
- bounce=1 -> pos sequence 0,1,…,7,6,…,0,1. No repeated endpoint.
- Channel left at bright=7, fade tick every 8 cycles, exponential -> 7,3,1,0 on successive ticks. Duty ≈ 8/8, 4/8, 2/8, then off. With SEG_FADE_LINEAR_EN -> 7,6,…,0 over 7 ticks.
- pause=1 for 50 cycles -> pos constant, step_pulse 0, trails still decay. Release -> step after remaining tmr count.
- Reset asserted mid-bounce descending -> next edge: pos=0, seg_out=8'hFF, heading up.
